pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard and control unit for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Generalises the existing EX-stage forwarding logic with the following additions:
  - load-use stall insertion
  - branch flush with a configurable resolve stage
  - whole-pipe freeze while data memory is busy, with a timeout
  - per-stage valid tracking
- Sits beside the pipeline registers and drives their write-enable and flush inputs, the PC write-enable and the ALU operand forwarding muxes.

---
 rtl/pipeline_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit for a 5-stage IF/ID/EX/MEM/WB pipeline: freeze, branch flush, load-use stall, forwarding.
// Optional performance counters are built when PIPELINE_HAZARD_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int TIMEOUT_W    = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_rs_id,
    input  logic [REG_ADDR_W-1:0] i_rt_id,
    input  logic                  i_uses_rt_id,
    input  logic [REG_ADDR_W-1:0] i_rs_ex,
    input  logic [REG_ADDR_W-1:0] i_rt_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_ex,
    input  logic                  i_memread_ex,
    input  logic                  i_regwrite_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_wb,
    input  logic                  i_regwrite_mem,
    input  logic                  i_regwrite_wb,
    input  logic                  i_branch_taken,
    input  logic                  i_mem_req,
    input  logic                  i_mem_ready,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_id_ex_write,
    output logic                  o_ex_mem_write,
    output logic                  o_mem_wb_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_flush,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b,
    output logic                  o_valid_id,
    output logic                  o_valid_ex,
    output logic                  o_valid_mem,
    output logic                  o_valid_wb,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_load_use_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt,
    output logic [CNT_W-1:0]      o_mem_wait_cnt
);

    generate
        if (BRANCH_STAGE != 1 && BRANCH_STAGE != 2) begin : g_bad_branch_stage
            $error("pipeline_hazard_ctrl: BRANCH_STAGE must be 1 (EX) or 2 (MEM)");
        end
    endgenerate

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic                 r_valid_id, r_valid_ex, r_valid_mem, r_valid_wb;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic                 r_timeout;

    logic w_freeze, w_branch, w_load_use, w_fwd_mem, w_fwd_wb;

    // Once timed out the pipe stays frozen regardless of mem_ready, until reset.
    assign w_freeze   = r_timeout | (r_valid_mem & i_mem_req & ~i_mem_ready);
    assign w_branch   = i_branch_taken & ((BRANCH_STAGE == 1) ? r_valid_ex : r_valid_mem);
    assign w_load_use = r_valid_ex & i_memread_ex & i_regwrite_ex & (i_rd_ex != '0) &
                        ((i_rd_ex == i_rs_id) | (i_uses_rt_id & (i_rd_ex == i_rt_id)));
    assign w_fwd_mem  = r_valid_mem & i_regwrite_mem & (i_rd_mem != '0);
    assign w_fwd_wb   = r_valid_wb & i_regwrite_wb & (i_rd_wb != '0);

    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_id_ex_write  = 1'b1;
        o_ex_mem_write = 1'b1;
        o_mem_wb_write = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        if (i_reset) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_write  = 1'b0;
            o_ex_mem_write = 1'b0;
            o_mem_wb_write = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if (w_freeze) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_write  = 1'b0;
            o_ex_mem_write = 1'b0;
            o_mem_wb_write = 1'b0;
        end else if (w_branch) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = (BRANCH_STAGE == 2);
        end else if (w_load_use) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        o_forward_a = 2'b00;
        o_forward_b = 2'b00;
        if (!i_reset) begin
            if (w_fwd_mem && (i_rd_mem == i_rs_ex))     o_forward_a = 2'b10;
            else if (w_fwd_wb && (i_rd_wb == i_rs_ex))  o_forward_a = 2'b01;
            if (w_fwd_mem && (i_rd_mem == i_rt_ex))     o_forward_b = 2'b10;
            else if (w_fwd_wb && (i_rd_wb == i_rt_ex))  o_forward_b = 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_id  <= 1'b0;
            r_valid_ex  <= 1'b0;
            r_valid_mem <= 1'b0;
            r_valid_wb  <= 1'b0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else if (w_freeze) begin
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == WAIT_LAST) r_timeout <= 1'b1;
        end else begin
            r_wait_cnt  <= '0;
            r_valid_wb  <= r_valid_mem;
            r_valid_mem <= r_valid_ex & ~o_ex_mem_flush;
            r_valid_ex  <= r_valid_id & ~o_id_ex_flush;
            if (o_if_id_write) r_valid_id <= ~o_if_id_flush;
        end
    end

    assign o_valid_id    = r_valid_id;
    assign o_valid_ex    = r_valid_ex;
    assign o_valid_mem   = r_valid_mem;
    assign o_valid_wb    = r_valid_wb;
    assign o_mem_timeout = r_timeout;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_load_use_cnt, r_flush_cnt, r_mem_wait_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_load_use_cnt <= '0;
            r_flush_cnt    <= '0;
            r_mem_wait_cnt <= '0;
        end else if (w_freeze) begin
            if (r_mem_wait_cnt != '1) r_mem_wait_cnt <= r_mem_wait_cnt + 1'b1;
        end else if (w_branch) begin
            if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
        end else if (w_load_use) begin
            if (r_load_use_cnt != '1) r_load_use_cnt <= r_load_use_cnt + 1'b1;
        end
    end

    assign o_load_use_cnt = r_load_use_cnt;
    assign o_flush_cnt    = r_flush_cnt;
    assign o_mem_wait_cnt = r_mem_wait_cnt;
`else
    assign o_load_use_cnt = '0;
    assign o_flush_cnt    = '0;
    assign o_mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control/forward/valid words are queued per cycle and compared mid-cycle.
module tb_pipeline_hazard_ctrl;
    localparam int RW = 5;
    localparam int CW = 16;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc, if_id, id_ex, ex_mem, mem_wb writes, if_id, id_ex, ex_mem flushes}
    localparam logic [7:0] C_RST = 8'b0000_0111;
    localparam logic [7:0] C_FRZ = 8'b0000_0000;
    localparam logic [7:0] C_NRM = 8'b1111_1000;
    localparam logic [7:0] C_LU  = 8'b0011_1010;
    localparam logic [7:0] C_BR  = 8'b1111_1111;

    typedef struct {
        string       nm;
        logic [16:0] v;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    logic clk = 1'b0;
    logic reset;
    logic [RW-1:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic uses_rt_id, memread_ex, regwrite_ex, regwrite_mem, regwrite_wb;
    logic branch_taken, mem_req, mem_ready;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] forward_a, forward_b;
    logic valid_id, valid_ex, valid_mem, valid_wb, mem_timeout;
    logic [CW-1:0] load_use_cnt, flush_cnt, mem_wait_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .BRANCH_STAGE(2), .TIMEOUT_W(4), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rt_id(uses_rt_id),
        .i_rs_ex(rs_ex), .i_rt_ex(rt_ex), .i_rd_ex(rd_ex),
        .i_memread_ex(memread_ex), .i_regwrite_ex(regwrite_ex),
        .i_rd_mem(rd_mem), .i_rd_wb(rd_wb),
        .i_regwrite_mem(regwrite_mem), .i_regwrite_wb(regwrite_wb),
        .i_branch_taken(branch_taken), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_id_ex_write(id_ex_write),
        .o_ex_mem_write(ex_mem_write), .o_mem_wb_write(mem_wb_write),
        .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush),
        .o_forward_a(forward_a), .o_forward_b(forward_b),
        .o_valid_id(valid_id), .o_valid_ex(valid_ex), .o_valid_mem(valid_mem), .o_valid_wb(valid_wb),
        .o_mem_timeout(mem_timeout),
        .o_load_use_cnt(load_use_cnt), .o_flush_cnt(flush_cnt), .o_mem_wait_cnt(mem_wait_cnt)
    );

    function automatic logic [16:0] obs();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                if_id_flush, id_ex_flush, ex_mem_flush, forward_a, forward_b,
                valid_id, valid_ex, valid_mem, valid_wb, mem_timeout};
    endfunction

    function automatic logic [47:0] cnts();
        return {load_use_cnt, flush_cnt, mem_wait_cnt};
    endfunction

    function automatic logic [47:0] exp_cnts(input int lu, input int fl, input int mw);
        logic [47:0] r;
        r = {lu[15:0], fl[15:0], mw[15:0]};
        return PERF ? r : 48'd0;
    endfunction

    task automatic push(input string nm, input logic [7:0] c, input logic [3:0] f,
                        input logic [3:0] v, input logic t);
        sb_t s;
        s.nm = nm;
        s.v  = {c, f, v, t};
        sb_q.push_back(s);
    endtask

    task automatic drive_idle();
        rs_id = '0; rt_id = '0; uses_rt_id = 1'b0;
        rs_ex = '0; rt_ex = '0; rd_ex = '0;
        memread_ex = 1'b0; regwrite_ex = 1'b0;
        rd_mem = '0; rd_wb = '0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic load_in_ex();
        rd_ex = 5'd2; memread_ex = 1'b1; regwrite_ex = 1'b1; rs_id = 5'd2;
    endtask

    task automatic test_reset();
        sb_t e;
        logic [3:0] vseq [5] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            if (i < 2) push($sformatf("reset_c%0d", i), C_RST, 4'b0000, 4'b0000, 1'b0);
            else begin
                reset = 1'b0;
                push($sformatf("release_c%0d", i - 2), C_NRM, 4'b0000, vseq[i-2], 1'b0);
            end
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            if (i == 1) begin
                total++;
                if (cnts() !== exp_cnts(0, 0, 0)) begin
                    bad++;
                    $display("FAIL reset_counters got=%012h want=%012h", cnts(), exp_cnts(0, 0, 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_forwarding();
        sb_t e;
        logic [3:0] ef;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            regwrite_mem = 1'b1;
            regwrite_wb  = 1'b1;
            case (i)
                0: begin rd_mem = 5; rd_wb = 5; rs_ex = 5; rt_ex = 5; ef = 4'b1010; end
                1: begin rd_mem = 0; rd_wb = 5; rs_ex = 5; rt_ex = 5; ef = 4'b0101; end
                2: begin rd_mem = 0; rd_wb = 0; rs_ex = 0; rt_ex = 0; ef = 4'b0000; end
                3: begin rd_mem = 5; rd_wb = 7; rs_ex = 7; rt_ex = 5; ef = 4'b0110; end
                default: begin
                    regwrite_mem = 1'b0; rd_mem = 7; rd_wb = 7; rs_ex = 7; rt_ex = 7; ef = 4'b0101;
                end
            endcase
            push($sformatf("fwd_%0d", i), C_NRM, ef, 4'b1111, 1'b0);
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        sb_t e;
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            case (i)
                0: begin
                    rd_ex = 2; memread_ex = 1'b1; regwrite_ex = 1'b1; rs_id = 3; rt_id = 2;
                    push("lu_rt_unused", C_NRM, 4'b0000, 4'b1111, 1'b0);
                end
                1: begin
                    rd_ex = 2; memread_ex = 1'b1; regwrite_ex = 1'b1; rs_id = 3; rt_id = 2;
                    uses_rt_id = 1'b1;
                    push("lu_stall", C_LU, 4'b0000, 4'b1111, 1'b0);
                end
                2: begin
                    rd_mem = 2; regwrite_mem = 1'b1; rs_ex = 3; rt_ex = 2;
                    push("lu_forward", C_NRM, 4'b0010, 4'b1011, 1'b0);
                end
                3: push("lu_refill0", C_NRM, 4'b0000, 4'b1101, 1'b0);
                4: push("lu_refill1", C_NRM, 4'b0000, 4'b1110, 1'b0);
                default: push("lu_refill2", C_NRM, 4'b0000, 4'b1111, 1'b0);
            endcase
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            if (i == 2) begin
                total++;
                if (cnts() !== exp_cnts(1, 0, 0)) begin
                    bad++;
                    $display("FAIL lu_counters got=%012h want=%012h", cnts(), exp_cnts(1, 0, 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        sb_t e;
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            case (i)
                0: begin
                    load_in_ex();
                    branch_taken = 1'b1;
                    push("br_flush", C_BR, 4'b0000, 4'b1111, 1'b0);
                end
                1: push("br_after", C_NRM, 4'b0000, 4'b0001, 1'b0);
                2: begin
                    branch_taken = 1'b1;
                    push("br_mem_invalid", C_NRM, 4'b0000, 4'b1000, 1'b0);
                end
                3: push("br_refill0", C_NRM, 4'b0000, 4'b1100, 1'b0);
                4: push("br_refill1", C_NRM, 4'b0000, 4'b1110, 1'b0);
                default: push("br_refill2", C_NRM, 4'b0000, 4'b1111, 1'b0);
            endcase
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            if (i == 1) begin
                total++;
                if (cnts() !== exp_cnts(1, 1, 0)) begin
                    bad++;
                    $display("FAIL br_counters got=%012h want=%012h", cnts(), exp_cnts(1, 1, 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_freeze();
        sb_t e;
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            if (i < 3) begin
                load_in_ex();
                mem_req = 1'b1; mem_ready = 1'b0;
                push($sformatf("frz_c%0d", i), C_FRZ, 4'b0000, 4'b1111, 1'b0);
            end else if (i == 3) begin
                load_in_ex();
                mem_req = 1'b1; mem_ready = 1'b1;
                push("frz_ready_lu", C_LU, 4'b0000, 4'b1111, 1'b0);
            end else if (i == 4) push("frz_after", C_NRM, 4'b0000, 4'b1011, 1'b0);
            else if (i == 5)     push("frz_refill0", C_NRM, 4'b0000, 4'b1101, 1'b0);
            else if (i == 6)     push("frz_refill1", C_NRM, 4'b0000, 4'b1110, 1'b0);
            else                 push("frz_refill2", C_NRM, 4'b0000, 4'b1111, 1'b0);
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            if (i == 3 || i == 4) begin
                total++;
                if (cnts() !== exp_cnts(i - 2, 1, 3)) begin
                    bad++;
                    $display("FAIL frz_counters_%0d got=%012h want=%012h", i, cnts(), exp_cnts(i - 2, 1, 3));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        sb_t e;
        for (int i = 0; i < 21; i++) begin
            drive_idle();
            if (i < 16) begin
                mem_req = 1'b1; mem_ready = 1'b0;
                push($sformatf("to_wait%0d", i), C_FRZ, 4'b0000, 4'b1111, (i == 15));
            end else if (i == 16) begin
                mem_req = 1'b1; mem_ready = 1'b1;
                push("to_sticky_ready", C_FRZ, 4'b0000, 4'b1111, 1'b1);
            end else if (i == 17) begin
                push("to_sticky_idle", C_FRZ, 4'b0000, 4'b1111, 1'b1);
            end else if (i == 18) begin
                reset = 1'b1;
                push("to_reset_c0", C_RST, 4'b0000, 4'b1111, 1'b1);
            end else if (i == 19) begin
                reset = 1'b1;
                push("to_reset_c1", C_RST, 4'b0000, 4'b0000, 1'b0);
            end else begin
                reset = 1'b0;
                push("to_release", C_NRM, 4'b0000, 4'b0000, 1'b0);
            end
            #2;
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s got=%05h want=%05h", e.nm, obs(), e.v);
            end
            if (i == 15 || i == 19) begin
                total++;
                if (cnts() !== ((i == 15) ? exp_cnts(2, 1, 18) : exp_cnts(0, 0, 0))) begin
                    bad++;
                    $display("FAIL to_counters_%0d got=%012h want=%012h", i, cnts(),
                             (i == 15) ? exp_cnts(2, 1, 18) : exp_cnts(0, 0, 0));
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
